// File: rtl/lsb_queue_pkg.sv
// lsb_queue_pkg: opcode/length encodings, FSM states and opcode helpers for the load/store queue
package lsb_queue_pkg;
  localparam int WORD = 32;
  localparam int ZERO_ROB_IDX = 0;
  localparam logic [5:0] OPT_LB  = 6'd1;
  localparam logic [5:0] OPT_LH  = 6'd2;
  localparam logic [5:0] OPT_LW  = 6'd3;
  localparam logic [5:0] OPT_LBU = 6'd4;
  localparam logic [5:0] OPT_LHU = 6'd5;
  localparam logic [5:0] OPT_SB  = 6'd6;
  localparam logic [5:0] OPT_SH  = 6'd7;
  localparam logic [5:0] OPT_SW  = 6'd8;
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_LD_WAIT, S_ST_WAIT} state_e;
  function automatic logic is_load(input logic [5:0] opt);
    return opt inside {OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU};
  endfunction
  function automatic logic [1:0] len_of(input logic [5:0] opt);
    return (opt inside {OPT_LB, OPT_LBU, OPT_SB}) ? LEN_B :
           (opt inside {OPT_LH, OPT_LHU, OPT_SH}) ? LEN_H : LEN_W;
  endfunction
endpackage

// File: rtl/lsb_ld_extend.sv
// lsb_ld_extend: sign/zero-extends raw memory read data according to the load opcode
module lsb_ld_extend
  import lsb_queue_pkg::*;
#(
  parameter int OPT_W = 6
) (
  input  logic [OPT_W-1:0] i_opt,
  input  logic [WORD-1:0]  i_raw,
  output logic [WORD-1:0]  o_val
);
  always_comb
    o_val = (i_opt == OPT_LB)  ? {{24{i_raw[7]}}, i_raw[7:0]} :
            (i_opt == OPT_LH)  ? {{16{i_raw[15]}}, i_raw[15:0]} :
            (i_opt == OPT_LBU) ? {24'd0, i_raw[7:0]} :
            (i_opt == OPT_LHU) ? {16'd0, i_raw[15:0]} : i_raw;
endmodule

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store buffer with CDB snooping, ROB-committed stores and
// rollback that keeps an already-committed store at the head
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int DEPTH_BIT   = 4,
  parameter int FULL_MARGIN = 3,
  parameter int ROB_BIT     = 4,
  parameter int CDB_N       = 2,
  parameter int OPT_W       = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    stall,
  output logic                    full,
  output logic                    empty,
  input  logic                    id_valid,
  input  logic [OPT_W-1:0]        id_opt,
  input  logic [ROB_BIT-1:0]      id_src1,
  input  logic [ROB_BIT-1:0]      id_src2,
  input  logic [WORD-1:0]         id_val1,
  input  logic [WORD-1:0]         id_val2,
  input  logic [WORD-1:0]         id_imm,
  input  logic [ROB_BIT-1:0]      id_rob_idx,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*ROB_BIT-1:0] cdb_src,
  input  logic [CDB_N*WORD-1:0]   cdb_val,
  output logic                    rob_st_ena,
  output logic [ROB_BIT-1:0]      rob_st_src,
  output logic [WORD-1:0]         rob_st_addr,
  output logic [WORD-1:0]         rob_st_val,
  input  logic                    rob_st_commit,
  input  logic [ROB_BIT-1:0]      rob_st_commit_idx,
  output logic                    mc_req,
  output logic                    mc_we,
  output logic [WORD-1:0]         mc_addr,
  output logic [1:0]              mc_len,
  output logic [WORD-1:0]         mc_wdata,
  input  logic                    mc_done,
  input  logic [WORD-1:0]         mc_rdata,
  output logic                    ld_out_valid,
  output logic [ROB_BIT-1:0]      ld_out_src,
  output logic [WORD-1:0]         ld_out_val
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam int CW = DEPTH_BIT + 1;
  localparam logic [ROB_BIT-1:0] NO_DEP = ROB_BIT'(ZERO_ROB_IDX);

  logic [DEPTH-1:0]     r_valid, r_rep, r_cmt;
  logic [OPT_W-1:0]     r_opt  [DEPTH];
  logic [ROB_BIT-1:0]   r_src1 [DEPTH];
  logic [ROB_BIT-1:0]   r_src2 [DEPTH];
  logic [ROB_BIT-1:0]   r_dest [DEPTH];
  logic [WORD-1:0]      r_val1 [DEPTH];
  logic [WORD-1:0]      r_val2 [DEPTH];
  logic [WORD-1:0]      r_imm  [DEPTH];
  logic [DEPTH_BIT-1:0] r_head, r_tail;
  logic [CW-1:0]        r_count;
  state_e               r_state;
  logic                 r_drop;
  logic [OPT_W-1:0]     r_ld_opt;
  logic [ROB_BIT-1:0]   r_ld_src;
  logic                 r_rob_st_ena, r_mc_req, r_mc_we, r_ld_out_valid;
  logic [ROB_BIT-1:0]   r_rob_st_src, r_ld_out_src;
  logic [WORD-1:0]      r_rob_st_addr, r_rob_st_val, r_mc_addr, r_mc_wdata, r_ld_out_val;
  logic [1:0]           r_mc_len;

  logic [ROB_BIT-1:0]   w_b_src1, w_b_src2;
  logic [WORD-1:0]      w_b_val1, w_b_val2, w_addr, w_ext;
  logic                 w_hv, w_hld, w_push, w_pop, w_issue_ld, w_report, w_issue_st, w_keep;

  lsb_ld_extend #(.OPT_W(OPT_W)) u_ext (.i_opt(r_ld_opt), .i_raw(mc_rdata), .o_val(w_ext));

  // Descending scan so the lowest-numbered matching channel is the one that sticks
  always_comb begin
    w_b_src1 = id_src1;
    w_b_val1 = id_val1;
    w_b_src2 = id_src2;
    w_b_val2 = id_val2;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (cdb_valid[k] && id_src1 != NO_DEP && id_src1 == cdb_src[k*ROB_BIT +: ROB_BIT]) begin
        w_b_src1 = NO_DEP;
        w_b_val1 = cdb_val[k*WORD +: WORD];
      end
      if (cdb_valid[k] && id_src2 != NO_DEP && id_src2 == cdb_src[k*ROB_BIT +: ROB_BIT]) begin
        w_b_src2 = NO_DEP;
        w_b_val2 = cdb_val[k*WORD +: WORD];
      end
    end
  end

  always_comb begin
    w_hv       = r_valid[r_head];
    w_hld      = is_load(r_opt[r_head]);
    w_addr     = r_val1[r_head] + r_imm[r_head];
    w_push     = id_valid && !stall && !flush && r_count != CW'(DEPTH);
    w_issue_ld = r_state == S_IDLE && w_hv && w_hld && r_src1[r_head] == NO_DEP && !flush;
    w_report   = r_state == S_IDLE && w_hv && !w_hld && !r_rep[r_head] && !flush &&
                 r_src1[r_head] == NO_DEP && r_src2[r_head] == NO_DEP;
    w_issue_st = r_state == S_IDLE && w_hv && !w_hld && r_rep[r_head] &&
                 (r_cmt[r_head] || (rob_st_commit && rob_st_commit_idx == r_dest[r_head]));
    w_pop      = w_issue_ld || (r_state == S_ST_WAIT && mc_done);
    w_keep     = r_state == S_ST_WAIT || w_issue_st;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_rep <= '0;
      r_cmt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_opt[i] <= '0;
        r_src1[i] <= '0;
        r_src2[i] <= '0;
        r_dest[i] <= '0;
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_imm[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_drop <= 1'b0;
      r_ld_opt <= '0;
      r_ld_src <= '0;
      r_rob_st_ena <= 1'b0;
      r_rob_st_src <= '0;
      r_rob_st_addr <= '0;
      r_rob_st_val <= '0;
      r_mc_req <= 1'b0;
      r_mc_we <= 1'b0;
      r_mc_addr <= '0;
      r_mc_len <= '0;
      r_mc_wdata <= '0;
      r_ld_out_valid <= 1'b0;
      r_ld_out_src <= '0;
      r_ld_out_val <= '0;
    end else if (rdy) begin
      r_rob_st_ena <= w_report;
      r_ld_out_valid <= 1'b0;
      if (w_report) begin
        r_rep[r_head] <= 1'b1;
        r_rob_st_src <= r_dest[r_head];
        r_rob_st_addr <= w_addr;
        r_rob_st_val <= r_val2[r_head];
      end
      for (int i = 0; i < DEPTH; i++)
        for (int k = CDB_N - 1; k >= 0; k--) begin
          if (r_valid[i] && cdb_valid[k] && r_src1[i] != NO_DEP && r_src1[i] == cdb_src[k*ROB_BIT +: ROB_BIT]) begin
            r_src1[i] <= NO_DEP;
            r_val1[i] <= cdb_val[k*WORD +: WORD];
          end
          if (r_valid[i] && cdb_valid[k] && r_src2[i] != NO_DEP && r_src2[i] == cdb_src[k*ROB_BIT +: ROB_BIT]) begin
            r_src2[i] <= NO_DEP;
            r_val2[i] <= cdb_val[k*WORD +: WORD];
          end
        end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_rep[r_tail] <= 1'b0;
        r_cmt[r_tail] <= 1'b0;
        r_opt[r_tail] <= id_opt;
        r_src1[r_tail] <= w_b_src1;
        r_src2[r_tail] <= w_b_src2;
        r_val1[r_tail] <= w_b_val1;
        r_val2[r_tail] <= w_b_val2;
        r_imm[r_tail] <= id_imm;
        r_dest[r_tail] <= id_rob_idx;
        r_tail <= r_tail + DEPTH_BIT'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head <= r_head + DEPTH_BIT'(1);
      end
      case (r_state)
        S_IDLE:
          if (w_issue_ld) begin
            r_mc_req <= 1'b1;
            r_mc_we <= 1'b0;
            r_mc_addr <= w_addr;
            r_mc_len <= len_of(r_opt[r_head]);
            r_ld_opt <= r_opt[r_head];
            r_ld_src <= r_dest[r_head];
            r_state <= S_LD_WAIT;
          end else if (w_issue_st) begin
            r_cmt[r_head] <= 1'b1;
            r_mc_req <= 1'b1;
            r_mc_we <= 1'b1;
            r_mc_addr <= w_addr;
            r_mc_len <= len_of(r_opt[r_head]);
            r_mc_wdata <= r_val2[r_head];
            r_state <= S_ST_WAIT;
          end
        S_LD_WAIT:
          if (mc_done) begin
            r_mc_req <= 1'b0;
            r_ld_out_valid <= !r_drop && !flush;
            r_ld_out_src <= r_ld_src;
            r_ld_out_val <= w_ext;
            r_drop <= 1'b0;
            r_state <= S_IDLE;
          end else if (flush) r_drop <= 1'b1;
        S_ST_WAIT:
          if (mc_done) begin
            r_mc_req <= 1'b0;
            r_state <= S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
      // A committed head store survives rollback; if it also completes now, the queue ends empty
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          if (!(w_keep && DEPTH_BIT'(i) == r_head)) r_valid[i] <= 1'b0;
        r_tail <= r_head + DEPTH_BIT'(w_keep);
        r_count <= CW'(w_keep && !w_pop);
      end
    end
  end

  assign full = r_count >= CW'(DEPTH - FULL_MARGIN);
  assign empty = r_count == '0;
  assign rob_st_ena = r_rob_st_ena;
  assign rob_st_src = r_rob_st_src;
  assign rob_st_addr = r_rob_st_addr;
  assign rob_st_val = r_rob_st_val;
  assign mc_req = r_mc_req;
  assign mc_we = r_mc_we;
  assign mc_addr = r_mc_addr;
  assign mc_len = r_mc_len;
  assign mc_wdata = r_mc_wdata;
  assign ld_out_valid = r_ld_out_valid;
  assign ld_out_src = r_ld_out_src;
  assign ld_out_val = r_ld_out_val;
endmodule

// File: tb/tb_lsb_queue.sv
// tb_lsb_queue: directed scenario bench for lsb_queue with hand-computed expectations
module tb_lsb_queue;
  import lsb_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, stall, full, empty;
  logic        id_valid;
  logic [5:0]  id_opt;
  logic [3:0]  id_src1, id_src2, id_rob_idx;
  logic [31:0] id_val1, id_val2, id_imm;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_src;
  logic [63:0] cdb_val;
  logic        rob_st_ena, rob_st_commit;
  logic [3:0]  rob_st_src, rob_st_commit_idx;
  logic [31:0] rob_st_addr, rob_st_val;
  logic        mc_req, mc_we, mc_done;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;
  logic [1:0]  mc_len;
  logic        ld_out_valid;
  logic [3:0]  ld_out_src;
  logic [31:0] ld_out_val;

  int n_cmp = 0;
  int n_bad = 0;

  lsb_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall), .full(full), .empty(empty),
    .id_valid(id_valid), .id_opt(id_opt), .id_src1(id_src1), .id_src2(id_src2),
    .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm), .id_rob_idx(id_rob_idx),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
    .rob_st_ena(rob_st_ena), .rob_st_src(rob_st_src), .rob_st_addr(rob_st_addr), .rob_st_val(rob_st_val),
    .rob_st_commit(rob_st_commit), .rob_st_commit_idx(rob_st_commit_idx),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_len(mc_len), .mc_wdata(mc_wdata),
    .mc_done(mc_done), .mc_rdata(mc_rdata),
    .ld_out_valid(ld_out_valid), .ld_out_src(ld_out_src), .ld_out_val(ld_out_val)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] opt, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                      input logic [3:0] rob);
    id_opt = opt; id_src1 = s1; id_src2 = s2; id_val1 = v1; id_val2 = v2; id_imm = imm;
    id_rob_idx = rob; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b0; id_opt = '0;
    id_src1 = '0; id_src2 = '0; id_val1 = '0; id_val2 = '0; id_imm = '0; id_rob_idx = '0;
    cdb_valid = '0; cdb_src = '0; cdb_val = '0; rob_st_commit = 1'b0; rob_st_commit_idx = '0;
    mc_done = 1'b0; mc_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (mc_req !== 1'b0) begin n_bad++; $display("FAIL reset_mc_req got=%b exp=0", mc_req); end
    n_cmp++; if (rob_st_ena !== 1'b0) begin n_bad++; $display("FAIL reset_st_ena got=%b exp=0", rob_st_ena); end
    n_cmp++; if ({ld_out_valid, ld_out_val} !== 33'd0) begin n_bad++; $display("FAIL reset_ld_out got=%b/%h exp=0/0", ld_out_valid, ld_out_val); end
  endtask

  task automatic test_rdy_freeze();
    rdy = 1'b0;
    push(OPT_LW, 4'd0, 4'd0, 32'h10, 32'h0, 32'h0, 4'd1);
    tick();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL freeze_empty got=%b exp=1", empty); end
    n_cmp++; if (mc_req !== 1'b0) begin n_bad++; $display("FAIL freeze_mc_req got=%b exp=0", mc_req); end
    rdy = 1'b1;
  endtask

  task automatic test_lw();
    push(OPT_LW, 4'd0, 4'd0, 32'h100, 32'h0, 32'd4, 4'd3);
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL lw_pushed_empty got=%b exp=0", empty); end
    tick();
    n_cmp++; if ({mc_req, mc_we} !== 2'b10) begin n_bad++; $display("FAIL lw_req_we got=%b exp=10", {mc_req, mc_we}); end
    n_cmp++; if (mc_addr !== 32'h104) begin n_bad++; $display("FAIL lw_addr got=%h exp=00000104", mc_addr); end
    n_cmp++; if (mc_len !== 2'd3) begin n_bad++; $display("FAIL lw_len got=%0d exp=3", mc_len); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL lw_popped_empty got=%b exp=1", empty); end
    mc_done = 1'b1; mc_rdata = 32'hDEADBEEF;
    tick();
    mc_done = 1'b0;
    n_cmp++; if (ld_out_valid !== 1'b1) begin n_bad++; $display("FAIL lw_out_valid got=%b exp=1", ld_out_valid); end
    n_cmp++; if (ld_out_val !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_out_val got=%h exp=deadbeef", ld_out_val); end
    n_cmp++; if (ld_out_src !== 4'd3) begin n_bad++; $display("FAIL lw_out_src got=%0d exp=3", ld_out_src); end
    n_cmp++; if (mc_req !== 1'b0) begin n_bad++; $display("FAIL lw_req_drop got=%b exp=0", mc_req); end
    tick();
    n_cmp++; if (ld_out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_out_pulse got=%b exp=0", ld_out_valid); end
  endtask

  task automatic test_ld_extend();
    logic [5:0]  opts [4] = '{OPT_LB, OPT_LBU, OPT_LH, OPT_LHU};
    logic [31:0] raws [4] = '{32'h80, 32'h80, 32'h8001, 32'h8001};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    logic [1:0]  lens [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      push(opts[i], 4'd0, 4'd0, 32'h40, 32'h0, 32'h0, 4'(i + 4));
      tick();
      n_cmp++; if (mc_len !== lens[i]) begin n_bad++; $display("FAIL ext%0d_len got=%0d exp=%0d", i, mc_len, lens[i]); end
      mc_done = 1'b1; mc_rdata = raws[i];
      tick();
      mc_done = 1'b0;
      n_cmp++; if ({ld_out_valid, ld_out_val} !== {1'b1, exps[i]}) begin n_bad++; $display("FAIL ext%0d_val got=%b/%h exp=1/%h", i, ld_out_valid, ld_out_val, exps[i]); end
    end
    tick();
  endtask

  task automatic test_store();
    push(OPT_SW, 4'd0, 4'd5, 32'h200, 32'h0, 32'd8, 4'd6);
    tick(); tick(); tick();
    n_cmp++; if ({rob_st_ena, mc_req} !== 2'b00) begin n_bad++; $display("FAIL st_blocked got=%b exp=00", {rob_st_ena, mc_req}); end
    cdb_valid = 2'b10; cdb_src = {4'd5, 4'd0}; cdb_val = {32'h1234, 32'h0};
    tick();
    cdb_valid = '0;
    tick();
    n_cmp++; if (rob_st_ena !== 1'b1) begin n_bad++; $display("FAIL st_report got=%b exp=1", rob_st_ena); end
    n_cmp++; if (rob_st_val !== 32'h1234) begin n_bad++; $display("FAIL st_report_val got=%h exp=00001234", rob_st_val); end
    n_cmp++; if ({rob_st_src, rob_st_addr} !== {4'd6, 32'h208}) begin n_bad++; $display("FAIL st_report_src_addr got=%0d/%h exp=6/00000208", rob_st_src, rob_st_addr); end
    tick();
    n_cmp++; if (rob_st_ena !== 1'b0) begin n_bad++; $display("FAIL st_report_pulse got=%b exp=0", rob_st_ena); end
    rob_st_commit = 1'b1; rob_st_commit_idx = 4'd6;
    tick();
    rob_st_commit = 1'b0;
    n_cmp++; if ({mc_req, mc_we} !== 2'b11) begin n_bad++; $display("FAIL st_req_we got=%b exp=11", {mc_req, mc_we}); end
    n_cmp++; if ({mc_wdata, mc_addr} !== {32'h1234, 32'h208}) begin n_bad++; $display("FAIL st_wdata_addr got=%h/%h exp=00001234/00000208", mc_wdata, mc_addr); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL st_wait_empty got=%b exp=0", empty); end
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    n_cmp++; if ({empty, mc_req} !== 2'b10) begin n_bad++; $display("FAIL st_done got=%b exp=10", {empty, mc_req}); end
  endtask

  task automatic test_bypass();
    cdb_valid = 2'b11; cdb_src = {4'd7, 4'd7}; cdb_val = {32'h80, 32'h40};
    push(OPT_LW, 4'd7, 4'd0, 32'h999, 32'h0, 32'h0, 4'd2);
    cdb_valid = '0;
    tick();
    n_cmp++; if ({mc_req, mc_addr} !== {1'b1, 32'h40}) begin n_bad++; $display("FAIL bypass_addr got=%b/%h exp=1/00000040", mc_req, mc_addr); end
    mc_done = 1'b1; mc_rdata = 32'h7;
    tick();
    mc_done = 1'b0;
    tick();
  endtask

  task automatic test_flush_store();
    push(OPT_SW, 4'd0, 4'd0, 32'h300, 32'hAA, 32'h0, 4'd2);
    tick();
    n_cmp++; if (rob_st_ena !== 1'b1) begin n_bad++; $display("FAIL fst_report got=%b exp=1", rob_st_ena); end
    rob_st_commit = 1'b1; rob_st_commit_idx = 4'd2;
    tick();
    rob_st_commit = 1'b0;
    n_cmp++; if ({mc_req, mc_we, mc_wdata} !== {2'b11, 32'hAA}) begin n_bad++; $display("FAIL fst_issue got=%b%b/%h exp=11/000000aa", mc_req, mc_we, mc_wdata); end
    for (int i = 0; i < 3; i++) push(OPT_LW, 4'd0, 4'd0, 32'h500, 32'h0, 32'h0, 4'(i + 3));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if ({empty, mc_req} !== 2'b01) begin n_bad++; $display("FAIL fst_after_flush got=%b exp=01", {empty, mc_req}); end
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    n_cmp++; if ({empty, mc_req} !== 2'b10) begin n_bad++; $display("FAIL fst_count_one got=%b exp=10", {empty, mc_req}); end
    tick();
    n_cmp++; if (mc_req !== 1'b0) begin n_bad++; $display("FAIL fst_discarded got=%b exp=0", mc_req); end
  endtask

  task automatic test_flush_load();
    push(OPT_LW, 4'd0, 4'd0, 32'h600, 32'h0, 32'h0, 4'd9);
    tick();
    flush = 1'b1; id_valid = 1'b1; id_opt = OPT_LW; id_src1 = 4'd0; id_rob_idx = 4'd10;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    n_cmp++; if ({empty, mc_req} !== 2'b11) begin n_bad++; $display("FAIL fld_flush_push got=%b exp=11", {empty, mc_req}); end
    mc_done = 1'b1; mc_rdata = 32'h55;
    tick();
    mc_done = 1'b0;
    n_cmp++; if ({ld_out_valid, mc_req} !== 2'b00) begin n_bad++; $display("FAIL fld_dropped got=%b exp=00", {ld_out_valid, mc_req}); end
    tick();
    n_cmp++; if ({ld_out_valid, mc_req} !== 2'b00) begin n_bad++; $display("FAIL fld_quiet got=%b exp=00", {ld_out_valid, mc_req}); end
  endtask

  task automatic test_full_count();
    for (int i = 0; i < 13; i++) begin
      push(OPT_LW, 4'd15, 4'd0, 32'h0, 32'h0, 32'(i * 4), 4'(i + 1));
      if (i == 11) begin
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_at12 got=%b exp=0", full); end
      end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_at13 got=%b exp=1", full); end
    cdb_valid = 2'b01; cdb_src = {4'd0, 4'd15}; cdb_val = {32'h0, 32'h1000};
    tick();
    cdb_valid = '0;
    push(OPT_LW, 4'd0, 4'd0, 32'h2000, 32'h0, 32'h0, 4'd14);
    n_cmp++; if ({full, mc_req, mc_addr} !== {2'b11, 32'h1000}) begin n_bad++; $display("FAIL full_pushpop got=%b%b/%h exp=11/00001000", full, mc_req, mc_addr); end
    mc_done = 1'b1; mc_rdata = 32'h0;
    tick();
    mc_done = 1'b0;
    n_cmp++; if ({ld_out_valid, ld_out_src} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL full_first_src got=%b/%0d exp=1/1", ld_out_valid, ld_out_src); end
    tick();
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_at12_again got=%b exp=0", full); end
    for (int i = 1; i < 14; i++) begin
      logic [31:0] exp_addr;
      exp_addr = (i < 13) ? 32'h1000 + 32'(i * 4) : 32'h2000;
      n_cmp++; if ({mc_req, mc_addr} !== {1'b1, exp_addr}) begin n_bad++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, mc_req, mc_addr, exp_addr); end
      mc_done = 1'b1;
      tick();
      mc_done = 1'b0;
      tick();
    end
    n_cmp++; if ({empty, mc_req} !== 2'b10) begin n_bad++; $display("FAIL drain_end got=%b exp=10", {empty, mc_req}); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      push(OPT_LW, 4'd0, 4'd0, 32'h5000, 32'h0, 32'(i * 16), 4'(i % 15 + 1));
      tick();
      n_cmp++; if (mc_addr !== 32'h5000 + 32'(i * 16)) begin n_bad++; $display("FAIL wrap%0d_addr got=%h exp=%h", i, mc_addr, 32'h5000 + 32'(i * 16)); end
      mc_done = 1'b1; mc_rdata = 32'(i);
      tick();
      mc_done = 1'b0;
      n_cmp++; if ({ld_out_valid, ld_out_src, ld_out_val} !== {1'b1, 4'(i % 15 + 1), 32'(i)}) begin n_bad++; $display("FAIL wrap%0d_out got=%b/%0d/%h exp=1/%0d/%h", i, ld_out_valid, ld_out_src, ld_out_val, i % 15 + 1, i); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_rdy_freeze();
    test_lw();
    test_ld_extend();
    test_store();
    test_bypass();
    test_flush_store();
    test_flush_load();
    test_full_count();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
